// File: rtl/seq_pkg.sv
// seq_pkg: shared state type, default sizing and CPU opcode constants for prog_sequencer.
package seq_pkg;

  localparam int unsigned SEQ_DEPTH   = 16;
  localparam int unsigned SEQ_TIMEOUT = 64;
  localparam int unsigned INSTR_W     = 16;

  // CPU opcode field (instr[15:13]) values used when building programs
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LOAD,
    KICK,
    WAIT_LOW,
    WAIT_HIGH,
    DONE
  } seq_state_t;

endpackage

// File: rtl/prog_mem.sv
// prog_mem: DEPTH x 16 instruction store, one synchronous write port, one combinational read port.
module prog_mem
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = SEQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] mem_d [DEPTH];

  // Write-port update of the array image
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage is deliberately not reset so a program survives a sequencer reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: feeds a stored program to the CPU through its in/load/s/w handshake.
// Optional watchdog on the CPU wait phases is enabled by defining SEQ_TIMEOUT_EN.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH   = SEQ_DEPTH,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned TIMEOUT = SEQ_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic [AW:0]        prog_len,
  input  logic               start,
  input  logic               cpu_w,
  output logic [INSTR_W-1:0] cpu_in,
  output logic               cpu_load,
  output logic               cpu_s,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [AW:0]        pc,
  output logic [AW:0]        retired
);

  localparam int unsigned  PW      = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  seq_state_t    state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [PW-1:0] retired_q, retired_d;
  logic [PW-1:0] len_q, len_d;
  logic [PW-1:0] pc_inc;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_q, load_d;
  logic          kick_q, kick_d;

  // Program memory; the host may only write while no run is in progress
  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (prog_we & ~busy_q),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc_q[AW-1:0]),
    .rdata (cpu_in)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          waiting;
  logic          wait_met;
  logic          wd_fire;

  // Watchdog fires when a wait state has stalled for a full TIMEOUT window
  always_comb begin
    waiting  = (state_q == SYNC) || (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
    wait_met = (state_q == WAIT_LOW) ? ~cpu_w : cpu_w;
    wd_fire  = waiting && !wait_met && (cnt_q == CW'(TIMEOUT - 1));
  end

  // Wait counter restarts on every state change
  always_comb begin
    cnt_d = (waiting && (state_d == state_q)) ? cnt_q + CW'(1) : '0;
  end

  assign err = err_q;
`else
  // TIMEOUT only sizes the watchdog; referenced here so both builds share one interface
  if (TIMEOUT == 0) begin : g_timeout_unused
  end

  assign err = 1'b0;
`endif

  // Next-state, counter and registered-output logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    len_d     = len_q;
    pc_inc    = pc_q + PW'(1);
`ifdef SEQ_TIMEOUT_EN
    err_d     = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = (prog_len > DEPTH_P) ? DEPTH_P : prog_len;
          pc_d      = '0;
          retired_d = '0;
`ifdef SEQ_TIMEOUT_EN
          err_d     = 1'b0;
`endif
          state_d   = (prog_len == '0) ? DONE : SYNC;
        end
      end
      SYNC: begin
        if (cpu_w) state_d = LOAD;
      end
      LOAD:     state_d = KICK;
      KICK:     state_d = WAIT_LOW;
      WAIT_LOW: begin
        if (!cpu_w) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (cpu_w) begin
          pc_d      = pc_inc;
          retired_d = retired_q + PW'(1);
          state_d   = (pc_inc == len_q) ? DONE : LOAD;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

`ifdef SEQ_TIMEOUT_EN
    if (wd_fire) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
`endif

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    load_d = (state_d == LOAD);
    kick_d = (state_d == KICK);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      kick_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      load_q    <= load_d;
      kick_q    <= kick_d;
`ifdef SEQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign cpu_load = load_q;
  assign cpu_s    = kick_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pc       = pc_q;
  assign retired  = retired_q;

endmodule
